fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage. Owns the word-addressed PC and drives instruction_memory's
//  combinational read port (imem_addr -> imem_rd, same cycle). Registers the fetched
//  word into the IF/ID pipeline register consumed by decode. Handles hazard stalls,
//  branch redirects from EX, local predecode of J (opcode 6'h3f) and a halt request.
// PARAMETERS
//  ADDR_W    6        PC / imem word-address width (64-word memory)
//  DATA_W    32       instruction width
//  CNT_W     32       width of fetched-instruction counter
// PORTS
//  clk              in   1       rising-edge clock
//  rst_n            in   1       asynchronous, active-low reset
//  imem_addr        out  ADDR_W  word address to instruction memory (= pc)
//  imem_rd          in   DATA_W  instruction word returned combinationally
//  stall            in   1       hazard unit: hold PC and IF/ID
//  redirect_valid   in   1       EX resolved taken branch / jump
//  redirect_target  in   ADDR_W  absolute word address for redirect
//  halt_req         in   1       stop fetching (sticky until reset)
//  if_id_instr      out  DATA_W  registered instruction
//  if_id_pc_plus1   out  ADDR_W  registered (pc+1) of that instruction
//  if_id_valid      out  1       IF/ID holds a real instruction
//  halted           out  1       FSM in HALT
//  fetch_count      out  CNT_W   number of instructions entered into IF/ID with valid=1
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=0, state=BOOT, if_id_instr=0, if_id_pc_plus1=0,
//   if_id_valid=0, halted=0, fetch_count=0. Reset mid-operation aborts everything.
//  FSM: BOOT -> RUN after one clock (no fetch in BOOT; pc stays 0, valid stays 0).
//   RUN -> HALT when halt_req=1 at a clock edge. HALT exits only via reset.
//  RUN next-PC priority (highest first):
//   1 redirect_valid: pc<=redirect_target; if_id_valid<=0 (flush), even if stall=1.
//   2 stall: pc and all IF/ID outputs hold; fetch_count holds.
//   3 imem_rd[31:26]==6'h3f (J): pc<=imem_rd[ADDR_W-1:0]; J word loaded into IF/ID
//     with valid=1 (decode treats as nop); upper target bits ignored.
//   4 else pc<=pc+1, modulo 2^ADDR_W (63 -> 0 wraps, no flag).
//  Non-flush, non-stall RUN cycle: if_id_instr<=imem_rd, if_id_pc_plus1<=pc+1 (wrapped),
//   if_id_valid<=1, fetch_count<=fetch_count+1 (wraps at 2^CNT_W).
//  halt_req and redirect_valid same edge: halt wins; pc held, if_id_valid<=0.
//  HALT: pc frozen, if_id_valid=0, halted=1, fetch_count frozen; stall/redirect ignored.
//  Latency: instruction at address A appears on if_id_* one clock after pc==A.
//   Redirect penalty: 1 bubble in IF/ID (plus downstream flushes, not ours).
//  imem_addr is a continuous assign of pc; no other combinational in->out paths.
// STRUCTURE
//  Shared header mips_defs.vh: OP_J=6'h3f, opcode field [31:26], FSM encodings
//   ST_BOOT=2'd0, ST_RUN=2'd1, ST_HALT=2'd2, ADDR_W default.
//  Sub-module pc_next_mux (combinational): inputs pc, imem_rd, redirect_*, stall;
//   outputs next_pc and is_jump. Fetch_unit keeps the FSM, PC, IF/ID and counter regs.
// TESTING (bench instantiates fetch_unit + instruction_memory with the boot program)
//  1 Reset then release: cycle0 pc=0 valid=0 (BOOT); next edges pc=1,2,3;
//    if_id_instr=32'h28020005 with pc_plus1=1, valid=1; fetch_count=1.
//  2 stall=1 for 3 cycles at pc=5: pc, if_id_instr=32'h00642800, fetch_count unchanged;
//    release -> pc=6 next edge.
//  3 redirect_valid=1, target=17 at pc=8 (with stall=1 too): next edge pc=17,
//    valid=0; following edge if_id_instr=32'h30050000, valid=1.
//  4 pc=15 fetches 32'hfc000011 (J): next pc=17, if_id_instr=32'hfc000011 valid=1;
//    address 16 never fetched.
//  5 Force redirect to 63 with imem[63]=0: pc goes 63 -> 0; if_id_pc_plus1=0.
//  6 halt_req=1 same edge as redirect_valid: halted=1, pc unchanged, valid=0; later
//    redirects ignored; rst_n pulse low mid-HALT -> all outputs at reset values.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: opcode field, J opcode and FSM encodings.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int OPC_HI     = 31;
  localparam int OPC_LO     = 26;

  localparam logic [5:0] OP_J = 6'h3f;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  function automatic logic is_j_op(input logic [5:0] opc);
    return opc == OP_J;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// Combinational next-PC select: redirect > stall > local J predecode > sequential.
module fetch_unit_pc_next_mux
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] imem_rd,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              is_jump
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Only the low target bits fit the memory; the rest of the J field is dropped.
  logic unused_target_hi;
  assign unused_target_hi = ^imem_rd[OPC_LO-1:ADDR_W];

  assign pc_plus1 = pc + ONE;
  assign is_jump  = is_j_op(imem_rd[OPC_HI:OPC_LO]);

  always_comb begin
    next_pc = pc_plus1;
    if (redirect_valid) begin
      next_pc = redirect_target;
    end else if (stall) begin
      next_pc = pc;
    end else if (is_jump) begin
      next_pc = imem_rd[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, IF/ID register, fetch counter and BOOT/RUN/HALT FSM.
//   state   | meaning
//   ST_BOOT | first clock after reset, no fetch
//   ST_RUN  | fetching, IF/ID updated per next-PC priority
//   ST_HALT | frozen until reset, IF/ID invalid
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rd,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt_req,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic              is_jump;

  // The jump decision is already folded into next_pc.
  logic unused_is_jump;
  assign unused_is_jump = is_jump;

  fetch_unit_pc_next_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pc_next_mux (
    .pc              (pc),
    .imem_rd         (imem_rd),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .next_pc         (next_pc),
    .pc_plus1        (pc_plus1),
    .is_jump         (is_jump)
  );

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_BOOT;
      pc             <= '0;
      if_id_instr    <= '0;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (halt_req) begin
            // Halt beats a same-edge redirect: PC holds, IF/ID is emptied.
            state       <= ST_HALT;
            if_id_valid <= 1'b0;
          end else if (redirect_valid) begin
            pc          <= next_pc;
            if_id_valid <= 1'b0;
          end else if (!stall) begin
            pc             <= next_pc;
            if_id_instr    <= imem_rd;
            if_id_pc_plus1 <= pc_plus1;
            if_id_valid    <= 1'b1;
            fetch_count    <= fetch_count + CNT_ONE;
          end
        end
        ST_HALT: begin
          if_id_valid <= 1'b0;
        end
        default: begin
          state       <= ST_BOOT;
          if_id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
